// File: rtl/hdc_main_if.sv
// Message/verdict bundle between the SMS front end and the HDC inference core.
// Latency: none, plain wires.
// Backpressure: none; the core watches msg/length continuously and publishes result.
interface hdc_main_if #(
    parameter int MSG_CHARS = 160
);
    logic [8*MSG_CHARS-1:0] msg;
    logic [7:0]             length;
    logic [8*MSG_CHARS-1:0] label;
    logic [1:0]             result;

    modport master (output msg, output length, output label, input result);
    modport slave  (input msg, input length, input label, output result);
endinterface

// File: rtl/hdc_main.sv
// HDC SMS classifier: item memory + positional rotation + majority bundling, then Hamming vote.
// Latency: result valid n+3 edges after the edge that sees a msg/length change (n = clamped length).
// Backpressure: none; any msg/length change aborts the current run and restarts from char 0.
module hdc_main #(
    parameter int           D         = 64,
    parameter int           MSG_CHARS = 160,
    parameter logic [D-1:0] BASE_HV   = 64'hA5C3_96E1_0F5A_3C87,
    parameter logic [D-1:0] HAM_HV    = '0,
    parameter logic [D-1:0] SPAM_HV   = '1
) (
    input  logic       clk,
    input  logic       reset,
    hdc_main_if.slave  bus
);
    localparam int         MW   = 8 * MSG_CHARS;
    localparam logic [7:0] MAXN = 8'(MSG_CHARS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ENCODE  = 2'd1;
    localparam logic [1:0] S_THRESH  = 2'd2;
    localparam logic [1:0] S_COMPARE = 2'd3;

    logic [1:0]    state;
    logic [MW-1:0] msg_q;
    logic [7:0]    len_q;
    logic [7:0]    idx;
    logic [7:0]    cnt [D];
    logic [D-1:0]  msg_hv;
    logic [1:0]    result_q;

    logic [7:0]    n_q;
    logic [7:0]    n_in;
    logic          changed;
    logic [7:0]    cur_char;
    logic [D-1:0]  item_c;
    logic [D-1:0]  bound;
    int            dist_ham;
    int            dist_spam;

    // label is a reference tag only; it never reaches any state or output
    logic unused_label;
    assign unused_label = ^bus.label;

    function automatic logic [D-1:0] rotl(input logic [D-1:0] v, input int s);
        // s is already reduced mod D; v >> D yields zero so s == 0 is safe
        return (v << s) | (v >> (D - s));
    endfunction

    assign n_q     = (len_q > MAXN) ? MAXN : len_q;
    assign n_in    = (bus.length > MAXN) ? MAXN : bus.length;
    assign changed = (bus.msg != msg_q) || (bus.length != len_q);

    // select the character being encoded this cycle (char 0 sits in the top byte)
    always_comb begin
        cur_char = 8'd0;
        for (int i = 0; i < MSG_CHARS; i++) begin
            if (idx == 8'(i)) cur_char = msg_q[MW-1-8*i -: 8];
        end
    end

    // item memory lookup and positional binding, purely combinational
    always_comb begin
        item_c = rotl(BASE_HV, int'(cur_char) % D) ^ {(D/8){cur_char}};
        bound  = rotl(item_c, int'(idx) % D);
    end

    // Hamming distances from the thresholded hypervector to both prototypes
    always_comb begin
        dist_ham  = $countones(msg_hv ^ HAM_HV);
        dist_spam = $countones(msg_hv ^ SPAM_HV);
    end

    // change detection, encode/threshold/compare sequencing and verdict register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            msg_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            msg_hv   <= '0;
            result_q <= 2'b00;
            for (int b = 0; b < D; b++) cnt[b] <= '0;
        end else if (changed) begin
            // new or altered message: relatch and restart regardless of current state
            msg_q    <= bus.msg;
            len_q    <= bus.length;
            idx      <= '0;
            result_q <= 2'b00;
            for (int b = 0; b < D; b++) cnt[b] <= '0;
            state    <= (n_in == 8'd0) ? S_THRESH : S_ENCODE;
        end else begin
            case (state)
                S_ENCODE: begin
                    for (int b = 0; b < D; b++) cnt[b] <= cnt[b] + {7'd0, bound[b]};
                    idx <= idx + 8'd1;
                    if (idx == n_q - 8'd1) state <= S_THRESH;
                end
                S_THRESH: begin
                    // strict majority: ties and empty messages give 0
                    for (int b = 0; b < D; b++) msg_hv[b] <= ({cnt[b], 1'b0} > {1'b0, n_q});
                    state <= S_COMPARE;
                end
                S_COMPARE: begin
                    if (dist_ham < dist_spam)      result_q <= 2'b01;
                    else if (dist_spam < dist_ham) result_q <= 2'b10;
                    else                           result_q <= 2'b11;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_hdc_main.sv
// Self-checking bench for hdc_main: four prototype configurations share one stimulus.
// Latency: checks sample 1 time unit after rising edges.
// Backpressure: none; stimulus changes restart the core as a real front end would.
module tb_hdc_main;
    localparam int          D    = 64;
    localparam int          NC   = 160;
    localparam logic [63:0] BASE = 64'hA5C3_96E1_0F5A_3C87;
    localparam logic [63:0] TIE  = 64'h0F0F_0F0F_0F0F_0F0F;

    // item vector from its definition: bit j = BASE[(j - c) mod D] xor c[j mod 8]
    function automatic logic [63:0] tb_item(input logic [7:0] c);
        logic [63:0] r;
        for (int j = 0; j < D; j++)
            r[j] = BASE[(j - (int'(c) % D) + D) % D] ^ c[j % 8];
        return r;
    endfunction

    localparam logic [63:0] ITEM_A = tb_item(8'h61);

    logic            clk;
    logic            reset;
    logic [8*NC-1:0] msg;
    logic [7:0]      length;
    logic [8*NC-1:0] label;
    logic [1:0]      res [4];
    logic [63:0]     hams [4];
    logic [63:0]     spams [4];
    int              n_checks;
    int              n_fail;

    hdc_main_if #(.MSG_CHARS(NC)) bus0 ();
    hdc_main_if #(.MSG_CHARS(NC)) bus1 ();
    hdc_main_if #(.MSG_CHARS(NC)) bus2 ();
    hdc_main_if #(.MSG_CHARS(NC)) bus3 ();

    assign bus0.msg = msg;  assign bus0.length = length;  assign bus0.label = label;
    assign bus1.msg = msg;  assign bus1.length = length;  assign bus1.label = label;
    assign bus2.msg = msg;  assign bus2.length = length;  assign bus2.label = label;
    assign bus3.msg = msg;  assign bus3.length = length;  assign bus3.label = label;
    assign res[0] = bus0.result;
    assign res[1] = bus1.result;
    assign res[2] = bus2.result;
    assign res[3] = bus3.result;

    hdc_main u_def (.clk(clk), .reset(reset), .bus(bus0));
    hdc_main #(.HAM_HV(ITEM_A), .SPAM_HV(~ITEM_A)) u_pa (.clk(clk), .reset(reset), .bus(bus1));
    hdc_main #(.HAM_HV(~ITEM_A), .SPAM_HV(ITEM_A)) u_pb (.clk(clk), .reset(reset), .bus(bus2));
    hdc_main #(.HAM_HV(TIE), .SPAM_HV(TIE)) u_tie (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference classifier: counts, majority, Hamming vote straight from the rules
    function automatic logic [1:0] model(input logic [8*NC-1:0] m, input logic [7:0] len,
                                         input logic [63:0] ham, input logic [63:0] spam);
        int          n;
        int          cnt [64];
        logic [63:0] it;
        logic [63:0] hv;
        logic [7:0]  c;
        int          dh;
        int          ds;
        n = (int'(len) > NC) ? NC : int'(len);
        for (int b = 0; b < D; b++) cnt[b] = 0;
        for (int i = 0; i < n; i++) begin
            c  = m[8*(NC-i)-1 -: 8];
            it = tb_item(c);
            for (int b = 0; b < D; b++) cnt[b] += int'(it[(b - (i % D) + D) % D]);
        end
        dh = 0;
        ds = 0;
        for (int b = 0; b < D; b++) begin
            hv[b] = (2 * cnt[b] > n);
            dh += int'(hv[b] != ham[b]);
            ds += int'(hv[b] != spam[b]);
        end
        if (dh < ds) return 2'b01;
        if (ds < dh) return 2'b10;
        return 2'b11;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_msg();
        for (int w = 0; w < 8*NC/32; w++) msg[32*w +: 32] = $urandom;
    endtask

    task automatic test_reset();
        #3;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res[k] !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_state inst%0d got=%b exp=00", k, res[k]);
            end
        end
        tick(2);
        reset = 1'b1;
        tick(5);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res[k] !== 2'b00) begin
                n_fail++;
                $display("FAIL zero_no_trigger inst%0d got=%b exp=00", k, res[k]);
            end
        end
    endtask

    task automatic test_len0();
        rand_msg();
        length = 8'd0;
        tick(2);
        n_checks++;
        if (res[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL len0_busy got=%b exp=00", res[0]);
        end
        tick(1);
        n_checks++;
        if (res[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL len0_ham got=%b exp=01", res[0]);
        end
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (res[k] !== model(msg, length, hams[k], spams[k])) begin
                n_fail++;
                $display("FAIL len0_model inst%0d got=%b exp=%b", k, res[k],
                         model(msg, length, hams[k], spams[k]));
            end
        end
    endtask

    task automatic test_proto();
        msg = '0;
        msg[8*NC-1 -: 8] = 8'h61;
        length = 8'd1;
        tick(3);
        n_checks++;
        if (res[1] !== 2'b00) begin
            n_fail++;
            $display("FAIL proto_busy got=%b exp=00", res[1]);
        end
        tick(1);
        n_checks++;
        if (res[1] !== 2'b01) begin
            n_fail++;
            $display("FAIL proto_ham got=%b exp=01", res[1]);
        end
        n_checks++;
        if (res[2] !== 2'b10) begin
            n_fail++;
            $display("FAIL proto_spam got=%b exp=10", res[2]);
        end
    endtask

    task automatic test_tie();
        rand_msg();
        length = 8'd5;
        tick(7);
        n_checks++;
        if (res[3] !== 2'b00) begin
            n_fail++;
            $display("FAIL tie_busy got=%b exp=00", res[3]);
        end
        tick(1);
        n_checks++;
        if (res[3] !== 2'b11) begin
            n_fail++;
            $display("FAIL tie_result got=%b exp=11", res[3]);
        end
        n_checks++;
        if (res[0] !== model(msg, length, hams[0], spams[0])) begin
            n_fail++;
            $display("FAIL tie_len5_model got=%b exp=%b", res[0], model(msg, length, hams[0], spams[0]));
        end
    endtask

    task automatic test_restart();
        logic [1:0] exp [4];
        rand_msg();
        length = 8'd40;
        tick(9);
        msg[8*(NC-17)-1 -: 8] = msg[8*(NC-17)-1 -: 8] ^ 8'h01;
        for (int k = 0; k < 4; k++) exp[k] = model(msg, length, hams[k], spams[k]);
        tick(42);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res[k] !== 2'b00) begin
                n_fail++;
                $display("FAIL restart_busy inst%0d got=%b exp=00", k, res[k]);
            end
        end
        tick(1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL restart_result inst%0d got=%b exp=%b", k, res[k], exp[k]);
            end
        end
        label = ~label;
        tick(2);
        n_checks++;
        if (res[0] !== exp[0]) begin
            n_fail++;
            $display("FAIL label_no_restart got=%b exp=%b", res[0], exp[0]);
        end
        tick(44);
        n_checks++;
        if (res[1] !== exp[1]) begin
            n_fail++;
            $display("FAIL label_hold got=%b exp=%b", res[1], exp[1]);
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] exp;
        msg = '0;
        msg[8*NC-1 -: 8]  = 8'h68;
        msg[8*NC-9 -: 8]  = 8'h69;
        length = 8'd2;
        exp = model(msg, length, hams[0], spams[0]);
        tick(5);
        n_checks++;
        if (res[0] !== exp) begin
            n_fail++;
            $display("FAIL hi_result got=%b exp=%b", res[0], exp);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (res[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_idle got=%b exp=00", res[0]);
        end
        reset = 1'b1;
        tick(2);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (res[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_encode got=%b exp=00", res[0]);
        end
        reset = 1'b1;
        tick(4);
        n_checks++;
        if (res[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_busy got=%b exp=00", res[0]);
        end
        tick(1);
        n_checks++;
        if (res[0] !== exp) begin
            n_fail++;
            $display("FAIL post_reset_result got=%b exp=%b", res[0], exp);
        end
    endtask

    task automatic test_random_len();
        logic [1:0] exp;
        int         n;
        for (int v = 0; v < 10; v++) begin
            rand_msg();
            n = $urandom_range(1, NC);
            length = 8'(n);
            exp = model(msg, length, hams[0], spams[0]);
            tick(n + 2);
            n_checks++;
            if (res[0] !== 2'b00) begin
                n_fail++;
                $display("FAIL rand_busy v%0d n=%0d got=%b exp=00", v, n, res[0]);
            end
            tick(1);
            n_checks++;
            if (res[0] !== exp) begin
                n_fail++;
                $display("FAIL rand_result v%0d n=%0d got=%b exp=%b", v, n, res[0], exp);
            end
        end
    endtask

    task automatic test_clamp();
        logic [1:0] exp [4];
        for (int v = 0; v < 20; v++) begin
            rand_msg();
            length = (v % 2 == 0) ? 8'd200 : 8'($urandom_range(161, 255));
            for (int k = 0; k < 4; k++) exp[k] = model(msg, 8'd160, hams[k], spams[k]);
            tick(162);
            n_checks++;
            if (res[0] !== 2'b00) begin
                n_fail++;
                $display("FAIL clamp_busy v%0d len=%0d got=%b exp=00", v, length, res[0]);
            end
            tick(1);
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (res[k] !== exp[k]) begin
                    n_fail++;
                    $display("FAIL clamp_big v%0d inst%0d got=%b exp=%b", v, k, res[k], exp[k]);
                end
            end
            length = 8'd160;
            tick(163);
            n_checks++;
            if (res[0] !== exp[0]) begin
                n_fail++;
                $display("FAIL clamp_160 v%0d got=%b exp=%b", v, res[0], exp[0]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hams[0]  = 64'h0;     spams[0] = {64{1'b1}};
        hams[1]  = ITEM_A;    spams[1] = ~ITEM_A;
        hams[2]  = ~ITEM_A;   spams[2] = ITEM_A;
        hams[3]  = TIE;       spams[3] = TIE;
        reset    = 1'b0;
        msg      = '0;
        length   = 8'd0;
        for (int w = 0; w < 8*NC/32; w++) label[32*w +: 32] = $urandom;

        test_reset();
        test_len0();
        test_proto();
        test_tie();
        test_restart();
        test_async_reset();
        test_random_len();
        test_clamp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
